// File: rtl/pio_out_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map, status bits,
// timer state encoding and the counter-width helper.
package pio_out_pkg;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_SET   = 2'd1;
   localparam logic [1:0] ADDR_CLR   = 2'd2;
   localparam logic [1:0] ADDR_PULSE = 2'd3;

   localparam int BUSY_BIT = 31;
   localparam int IRQ_BIT  = 30;
   localparam int RD_LAT   = 1;

   typedef enum logic [0:0] {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   // A one-cycle pulse still needs a 1-bit counter to hold its zero value.
   function automatic int cnt_width(input int cycles);
      if (cycles > 1) begin
         return $clog2(cycles);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse down-counter with busy flag; load (re)starts a PULSE_CYCLES window, abort ends it.
// expire flags the natural end of a window that is not being overridden by load/abort.
module pio_pulse_timer
   import pio_out_pkg::*;
#(
   parameter int PULSE_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic abort,
   output logic busy,
   output logic expire
);

   localparam int CW = cnt_width(PULSE_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   tmr_state_e     state_r;
   tmr_state_e     state_nxt_s;
   logic [CW-1:0]  cnt_r;
   logic [CW-1:0]  cnt_nxt_s;
   logic           cnt_zero_s;

   assign cnt_zero_s = (cnt_r == CNT_ZERO);

   // State and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= TMR_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic: a load always wins over abort and natural expiry
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         TMR_IDLE: begin
            if (load) begin
               state_nxt_s = TMR_RUN;
               cnt_nxt_s   = CNT_LOAD;
            end else begin
               state_nxt_s = TMR_IDLE;
            end
         end
         TMR_RUN: begin
            if (load) begin
               cnt_nxt_s = CNT_LOAD;
            end else if (abort) begin
               state_nxt_s = TMR_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_zero_s) begin
               state_nxt_s = TMR_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            state_nxt_s = TMR_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Output decode
   always_comb begin
      busy   = 1'b0;
      expire = 1'b0;
      case (state_r)
         TMR_IDLE: begin
            busy   = 1'b0;
            expire = 1'b0;
         end
         TMR_RUN: begin
            busy   = 1'b1;
            expire = cnt_zero_s & ~load & ~abort;
         end
         default: begin
            busy   = 1'b0;
            expire = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM output PIO with direct/set/clear writes and a timed inverting pulse.
// Optional sticky expiry interrupt enabled by defining PIO_PULSE_OUT_IRQ_EN.
module pio_pulse_out
   import pio_out_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
   parameter int               PULSE_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
`ifdef PIO_PULSE_OUT_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

   logic              wr_s;
   logic [WIDTH-1:0]  wd_s;
   logic              unused_wd_s;
   logic [WIDTH-1:0]  data_r;
   logic [WIDTH-1:0]  data_nxt_s;
   logic [WIDTH-1:0]  mask_r;
   logic [WIDTH-1:0]  mask_nxt_s;
   logic [WIDTH-1:0]  out_nxt_s;
   logic [31:0]       rd_nxt_s;
   logic              pulse_wr_s;
   logic              load_s;
   logic              abort_s;
   logic              busy_s;
   logic              busy_nxt_s;
   logic              expire_s;
   logic              irq_bit_s;

   assign wr_s        = chipselect & ~write_n;
   assign wd_s        = writedata[WIDTH-1:0];
   assign unused_wd_s = ^writedata[31:WIDTH];

   pio_pulse_timer #(
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .abort  (abort_s),
      .busy   (busy_s),
      .expire (expire_s)
   );

   // Write decode; a PULSE write overrides a same-cycle expiry because expire is already masked by it
   always_comb begin
      data_nxt_s = data_r;
      mask_nxt_s = expire_s ? ZERO_W : mask_r;
      pulse_wr_s = 1'b0;
      load_s     = 1'b0;
      abort_s    = 1'b0;
      if (wr_s) begin
         case (address)
            ADDR_DATA:  data_nxt_s = wd_s;
            ADDR_SET:   data_nxt_s = data_r | wd_s;
            ADDR_CLR:   data_nxt_s = data_r & ~wd_s;
            ADDR_PULSE: begin
               pulse_wr_s = 1'b1;
               mask_nxt_s = wd_s;
               load_s     = |wd_s;
               abort_s    = ~(|wd_s);
            end
            default: data_nxt_s = data_r;
         endcase
      end else begin
         pulse_wr_s = 1'b0;
      end
   end

   // Output pins follow next-cycle data with the next-cycle pulse mask applied
   always_comb begin
      busy_nxt_s = load_s | (busy_s & ~abort_s & ~expire_s);
      out_nxt_s  = data_nxt_s ^ (busy_nxt_s ? mask_nxt_s : ZERO_W);
   end

   // Read mux over current (pre-update) register state
   always_comb begin
      rd_nxt_s = 32'd0;
      case (address)
         ADDR_DATA:  rd_nxt_s[WIDTH-1:0] = data_r;
         ADDR_SET:   rd_nxt_s[WIDTH-1:0] = out_port;
         ADDR_CLR:   rd_nxt_s = 32'd0;
         ADDR_PULSE: begin
            rd_nxt_s[WIDTH-1:0] = mask_r;
            rd_nxt_s[BUSY_BIT]  = busy_s;
            rd_nxt_s[IRQ_BIT]   = irq_bit_s;
         end
         default: rd_nxt_s = 32'd0;
      endcase
   end

   // Register file, output pins and read data
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r   <= RESET_VALUE;
         mask_r   <= ZERO_W;
         out_port <= RESET_VALUE;
         readdata <= 32'd0;
      end else begin
         data_r   <= data_nxt_s;
         mask_r   <= mask_nxt_s;
         out_port <= out_nxt_s;
         readdata <= rd_nxt_s;
      end
   end

`ifdef PIO_PULSE_OUT_IRQ_EN
   logic irq_r;

   // Sticky expiry interrupt; any PULSE-register write clears it with priority
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_r <= 1'b0;
      end else if (pulse_wr_s) begin
         irq_r <= 1'b0;
      end else if (expire_s) begin
         irq_r <= 1'b1;
      end else begin
         irq_r <= irq_r;
      end
   end

   assign irq       = irq_r;
   assign irq_bit_s = irq_r;
`else
   assign irq_bit_s = 1'b0;
`endif

endmodule
